// File: rtl/motor_arm_controller.sv
// motor_arm_controller: arming, failsafe and update-rate control between the
// mixer and the PWM generator. Generates the control-loop update tick, watches
// receiver frame activity, runs the arm/disarm FSM and gates the motor rates.
// Optional feature macro: MOTOR_IDLE_SPIN_EN (armed outputs clamp up to IDLE_RATE).
module motor_arm_controller #(
   parameter int REC_VAL_BIT_WIDTH    = 14,
   parameter int AUX_VAL_BIT_WIDTH    = 4,
   parameter int MOTOR_RATE_BIT_WIDTH = 36,
   parameter int UPDATE_DIVIDER       = 133000,
   parameter int FRAME_TIMEOUT        = 3990000,
   parameter int ARM_HOLD_TICKS       = 1000,
   parameter int ARM_SWITCH_THRESH    = 8,
   parameter int THROTTLE_LOW_MAX     = 100,
   parameter logic [MOTOR_RATE_BIT_WIDTH-1:0] IDLE_RATE = '0
) (
   input  logic                            sys_clk,
   input  logic                            rst,
   input  logic [REC_VAL_BIT_WIDTH-1:0]    throttle_val,
   input  logic [AUX_VAL_BIT_WIDTH-1:0]    aux1_val,
   input  logic                            rec_frame,
   input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate_in,
   input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate_in,
   input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate_in,
   input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate_in,
   output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate,
   output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate,
   output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate,
   output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate,
   output logic                            update_tick,
   output logic                            armed,
   output logic                            failsafe,
   output logic [2:0]                      ctrl_state
);

   localparam int NUM_MOTORS = 4;
   localparam int DIV_W  = (UPDATE_DIVIDER > 1) ? $clog2(UPDATE_DIVIDER) : 1;
   localparam int FRM_W  = $clog2(FRAME_TIMEOUT + 1);
   localparam int HOLD_W = $clog2(ARM_HOLD_TICKS + 1);

   typedef enum logic [2:0] {
      ST_DISARMED = 3'd0,
      ST_ARMING   = 3'd1,
      ST_ARMED    = 3'd2,
      ST_FAILSAFE = 3'd3
   } state_t;

   state_t state_q, state_d;

   logic [DIV_W-1:0]  div_q, div_d;
   logic              tick_q, tick_d;
   logic [FRM_W-1:0]  frm_q, frm_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              sw_low_q, sw_low_d;

   logic [NUM_MOTORS-1:0][MOTOR_RATE_BIT_WIDTH-1:0] mot_in, mot_ld, mot_q, mot_d;

   logic link_ok, aux_on, thr_low, arm_ok, div_wrap;

   assign mot_in = {motor_4_rate_in, motor_3_rate_in, motor_2_rate_in, motor_1_rate_in};

   assign div_wrap = (div_q == DIV_W'(UPDATE_DIVIDER - 1));
   assign link_ok  = (frm_q < FRM_W'(FRAME_TIMEOUT));
   assign aux_on   = (aux1_val >= AUX_VAL_BIT_WIDTH'(ARM_SWITCH_THRESH));
   assign thr_low  = (throttle_val <= REC_VAL_BIT_WIDTH'(THROTTLE_LOW_MAX));
   assign arm_ok   = aux_on && thr_low && link_ok && sw_low_q;

   // Divider, link monitor and switch-low latch next-state logic.
   always_comb begin
      div_d  = div_wrap ? '0 : div_q + 1'b1;
      tick_d = div_wrap;
      frm_d  = frm_q;
      if (rec_frame)
         frm_d = '0;
      else if (link_ok)
         frm_d = frm_q + 1'b1;
      sw_low_d = sw_low_q;
      // Entering ARMED consumes the latch so the switch must cycle off to re-arm.
      if (state_d == ST_ARMED && state_q != ST_ARMED)
         sw_low_d = 1'b0;
      else if (!aux_on)
         sw_low_d = 1'b1;
   end

   // Arm/disarm FSM next state and hold counter.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         ST_DISARMED: begin
            if (arm_ok) begin
               hold_d  = '0;
               state_d = ST_ARMING;
            end
         end
         ST_ARMING: begin
            if (!arm_ok)
               state_d = ST_DISARMED;
            else if (tick_q) begin
               hold_d = hold_q + 1'b1;
               if (hold_q >= HOLD_W'(ARM_HOLD_TICKS - 1))
                  state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // Link loss outranks the switch so a dropped link always lands in FAILSAFE.
            if (!link_ok)
               state_d = ST_FAILSAFE;
            else if (!aux_on)
               state_d = ST_DISARMED;
         end
         ST_FAILSAFE: begin
            if (link_ok && !aux_on)
               state_d = ST_DISARMED;
         end
         default: state_d = ST_DISARMED;
      endcase
   end

   // Per-motor load value, optionally clamped up to the idle rate.
   always_comb begin
      mot_ld = mot_in;
`ifdef MOTOR_IDLE_SPIN_EN
      for (int i = 0; i < NUM_MOTORS; i++)
         if (mot_in[i] < IDLE_RATE)
            mot_ld[i] = IDLE_RATE;
`endif
   end

`ifndef MOTOR_IDLE_SPIN_EN
   logic unused_idle_rate;
   assign unused_idle_rate = ^IDLE_RATE;
`endif

   // Motor gating: sample on ticks while armed, zero in every other state.
   always_comb begin
      mot_d = mot_q;
      for (int i = 0; i < NUM_MOTORS; i++) begin
         if (state_q != ST_ARMED)
            mot_d[i] = '0;
         else if (tick_q)
            mot_d[i] = mot_ld[i];
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk) begin
      if (rst)
         state_q <= ST_DISARMED;
      else
         state_q <= state_d;
   end

   // Datapath registers: divider, tick, frame counter, hold counter, latch, motors.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         div_q    <= '0;
         tick_q   <= 1'b0;
         frm_q    <= FRM_W'(FRAME_TIMEOUT);
         hold_q   <= '0;
         sw_low_q <= 1'b0;
         mot_q    <= '0;
      end else begin
         div_q    <= div_d;
         tick_q   <= tick_d;
         frm_q    <= frm_d;
         hold_q   <= hold_d;
         sw_low_q <= sw_low_d;
         mot_q    <= mot_d;
      end
   end

   assign update_tick  = tick_q;
   assign armed        = (state_q == ST_ARMED);
   assign failsafe     = (state_q == ST_FAILSAFE);
   assign ctrl_state   = state_q;
   assign motor_1_rate = mot_q[0];
   assign motor_2_rate = mot_q[1];
   assign motor_3_rate = mot_q[2];
   assign motor_4_rate = mot_q[3];

endmodule

// File: tb/tb_motor_arm_controller.sv
// tb_motor_arm_controller: directed scenarios plus randomized traffic, every
// cycle checked against a behavioural model of the arming controller.
module tb_motor_arm_controller;

   localparam int DIV = 4;
   localparam int FTO = 20;
   localparam int HLD = 3;
   localparam logic [35:0] IDLE = 36'd200;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic [13:0] throttle_val;
   logic [3:0]  aux1_val;
   logic        rec_frame;
   logic [35:0] min [4];
   logic [35:0] mout [4];
   logic        update_tick, armed, failsafe;
   logic [2:0]  ctrl_state;

   motor_arm_controller #(
      .UPDATE_DIVIDER(DIV), .FRAME_TIMEOUT(FTO), .ARM_HOLD_TICKS(HLD),
      .IDLE_RATE(IDLE)
   ) dut (
      .sys_clk(sys_clk), .rst(rst),
      .throttle_val(throttle_val), .aux1_val(aux1_val), .rec_frame(rec_frame),
      .motor_1_rate_in(min[0]), .motor_2_rate_in(min[1]),
      .motor_3_rate_in(min[2]), .motor_4_rate_in(min[3]),
      .motor_1_rate(mout[0]), .motor_2_rate(mout[1]),
      .motor_3_rate(mout[2]), .motor_4_rate(mout[3]),
      .update_tick(update_tick), .armed(armed), .failsafe(failsafe),
      .ctrl_state(ctrl_state)
   );

   always #5 sys_clk = ~sys_clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   bit frame_en = 1'b1;

   // Reference model: mode 0 disarmed, 1 arming, 2 armed, 3 failsafe.
   int          m_mode;
   int          m_edges;      // edges since reset
   int          m_since;      // edges since last frame, saturating at FTO
   int          m_ticks_held; // ticks counted while arming
   bit          m_tick;
   bit          m_sw_off_seen;
   logic [35:0] m_mot [4];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [35:0] armed_val(input logic [35:0] v);
`ifdef MOTOR_IDLE_SPIN_EN
      return (v < IDLE) ? IDLE : v;
`else
      return v;
`endif
   endfunction

   task automatic model_reset();
      m_mode = 0; m_edges = 0; m_since = FTO; m_ticks_held = 0;
      m_tick = 0; m_sw_off_seen = 0;
      for (int i = 0; i < 4; i++) m_mot[i] = '0;
   endtask

   // One clock: evaluate the model on the current inputs, clock, then compare.
   task automatic step();
      bit link, sw_on, low_thr, can_arm;
      int nxt;
      rec_frame = frame_en && (cyc % 10 == 0);
      cyc++;
      if (rst) model_reset();
      else begin
         link    = (m_since < FTO);
         sw_on   = (aux1_val >= 8);
         low_thr = (throttle_val <= 100);
         can_arm = sw_on && low_thr && link && m_sw_off_seen;
         for (int i = 0; i < 4; i++)
            if (m_mode != 2) m_mot[i] = '0;
            else if (m_tick) m_mot[i] = armed_val(min[i]);
         nxt = m_mode;
         if (m_mode == 0) begin
            if (can_arm) begin nxt = 1; m_ticks_held = 0; end
         end else if (m_mode == 1) begin
            if (!can_arm) nxt = 0;
            else if (m_tick) begin
               m_ticks_held++;
               if (m_ticks_held == HLD) nxt = 2;
            end
         end else if (m_mode == 2) begin
            if (!link) nxt = 3;
            else if (!sw_on) nxt = 0;
         end else begin
            if (link && !sw_on) nxt = 0;
         end
         if (nxt == 2 && m_mode != 2) m_sw_off_seen = 0;
         else if (!sw_on) m_sw_off_seen = 1;
         m_mode = nxt;
         m_since = rec_frame ? 0 : ((m_since < FTO) ? m_since + 1 : FTO);
         m_edges++;
         m_tick = (m_edges % DIV == 0);
      end
      @(posedge sys_clk);
      #1;
      chk("ctrl_state", ctrl_state, m_mode);
      chk("armed", armed, m_mode == 2);
      chk("failsafe", failsafe, m_mode == 3);
      chk("update_tick", update_tick, m_tick);
      for (int i = 0; i < 4; i++) chk("motor", mout[i], m_mot[i]);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic set_all(input logic [35:0] v);
      for (int i = 0; i < 4; i++) min[i] = v;
   endtask

   task automatic arm_seq();
      aux1_val = 4'd0; throttle_val = 14'd50; frame_en = 1'b1;
      run(12);
      aux1_val = 4'd12;
      run(30);
   endtask

   initial begin
      rst = 1'b1; throttle_val = 14'd50; aux1_val = 4'd0; rec_frame = 1'b0;
      set_all(36'd1000);
      model_reset();
      run(2);
      chk("reset_state", ctrl_state, 3'd0);
      chk("reset_motor", mout[0], 36'd0);
      rst = 1'b0;

      // 1: basic arm sequence
      arm_seq();
      chk("s1_armed", armed, 1'b1);
      chk("s1_motor", mout[2], 36'd1000);

      // 2: power-up with switch on cannot arm
      rst = 1'b1; aux1_val = 4'd12; run(1); rst = 1'b0;
      run(40);
      chk("s2_blocked", ctrl_state, 3'd0);
      chk("s2_motor", mout[0], 36'd0);
      arm_seq();
      chk("s2_armed", armed, 1'b1);

      // 3: high throttle blocks arming, and aborts arming midway
      aux1_val = 4'd0; run(10);
      throttle_val = 14'd500; aux1_val = 4'd12; run(30);
      chk("s3_blocked", ctrl_state, 3'd0);
      throttle_val = 14'd50; run(6);
      chk("s3_arming", ctrl_state, 3'd1);
      throttle_val = 14'd500; run(1);
      chk("s3_abort", ctrl_state, 3'd0);
      throttle_val = 14'd50; run(30);
      chk("s3_rearmed", armed, 1'b1);

      // 4: link loss -> failsafe, stays until switch off
      frame_en = 1'b0; run(25);
      chk("s4_failsafe", failsafe, 1'b1);
      chk("s4_motor", mout[1], 36'd0);
      frame_en = 1'b1; run(20);
      chk("s4_hold", ctrl_state, 3'd3);
      aux1_val = 4'd0; run(3);
      chk("s4_disarm", ctrl_state, 3'd0);

      // 5a: timeout and switch-off in the same cycle -> failsafe
      arm_seq();
      frame_en = 1'b0;
      for (int k = 0; k < 40 && m_since < FTO; k++) step();
      chk("s5_expiry_reached", m_since == FTO && armed, 1'b1);
      aux1_val = 4'd0; run(1);
      chk("s5_priority", ctrl_state, 3'd3);
      // 5b: reset while armed with motors running
      frame_en = 1'b1; run(20);
      arm_seq();
      chk("s5_pre_rst", mout[0], 36'd1000);
      rst = 1'b1; run(1);
      chk("s5_rst_motor", mout[0], 36'd0);
      chk("s5_rst_state", ctrl_state, 3'd0);
      rst = 1'b0;

      // 6: idle clamp (or pass-through)
      arm_seq();
      min[0] = 36'd150; min[1] = 36'd900; min[2] = 36'd150; min[3] = 36'd900;
      run(10);
`ifdef MOTOR_IDLE_SPIN_EN
      chk("s6_m1", mout[0], 36'd200);
`else
      chk("s6_m1", mout[0], 36'd150);
`endif
      chk("s6_m2", mout[1], 36'd900);

      // Randomized traffic
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 29) == 0)
            aux1_val = $urandom_range(0, 1) ? 4'd12 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0)
            case ($urandom_range(0, 3))
               0: throttle_val = 14'd50;
               1: throttle_val = 14'd100;
               2: throttle_val = 14'd101;
               default: throttle_val = 14'($urandom_range(0, 16383));
            endcase
         if ($urandom_range(0, 79) == 0) frame_en = ~frame_en;
         if ($urandom_range(0, 4) == 0)
            min[$urandom_range(0, 3)] = {4'($urandom), 32'($urandom)};
         rst = ($urandom_range(0, 399) == 0);
         step();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
